// File: rtl/pwm_duty_ctrl_if.sv
// pwm_duty_ctrl_if: button/ramp controls in, PWM generator step pulses and level shadow out
// Ports (controller view, modport master):
//   btn_up, btn_dn   in   raw asynchronous buttons, active high
//   ramp_mode        in   1 = automatic ramp toward target, 0 = manual
//   target[3:0]      in   ramp target, clamped to MAX_LEVEL inside the controller
//   duty_inc/dec     out  one-cycle step pulses to the PWM generator
//   duty_level[3:0]  out  shadow of the generator level
//   busy             out  ramp still moving toward the clamped target
interface pwm_duty_ctrl_if;
    logic       btn_up;
    logic       btn_dn;
    logic       ramp_mode;
    logic [3:0] target;
    logic       duty_inc;
    logic       duty_dec;
    logic [3:0] duty_level;
    logic       busy;
    modport master (
        input  btn_up, btn_dn, ramp_mode, target,
        output duty_inc, duty_dec, duty_level, busy
    );
    modport slave (
        output btn_up, btn_dn, ramp_mode, target,
        input  duty_inc, duty_dec, duty_level, busy
    );
endinterface

// File: rtl/pwm_duty_ctrl.sv
// pwm_duty_ctrl: debounced buttons or timed ramp drive inc/dec pulses to a PWM generator
// Ports:
//   clk     in  single clock
//   rst_n   in  asynchronous active-low reset
//   ctl_if  master modport of pwm_duty_ctrl_if (buttons, ramp controls, pulses, level, busy)
module pwm_duty_ctrl #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int RAMP_INTERVAL   = 1000,
    parameter int MAX_LEVEL       = 10,
    parameter int RESET_LEVEL     = 5
) (
    input logic              clk,
    input logic              rst_n,
    pwm_duty_ctrl_if.master  ctl_if
);
    typedef enum logic [1:0] {IDLE, PULSE, HOLD, RAMP_WAIT} state_t;
    localparam logic [3:0]  MAX_L   = 4'(MAX_LEVEL);
    localparam logic [3:0]  RST_L   = 4'(RESET_LEVEL);
    localparam logic [7:0]  DB_N    = 8'(DEBOUNCE_CYCLES);
    localparam logic [15:0] RAMP_TC = 16'(RAMP_INTERVAL - 1);
    // bit 0 = up button, bit 1 = down button
    logic [1:0]      meta_q, sync_q, db_q, db_d, req_q, req_d, hit;
    logic [1:0][7:0] cnt_q, cnt_d;
    state_t          state_q;
    logic            inc_q, dec_q, busy_q;
    logic [3:0]      level_q, tgt_c;
    logic [15:0]     timer_q;
    assign tgt_c = (ctl_if.target > MAX_L) ? MAX_L : ctl_if.target;
    // hit: the synchronized level has differed for DEBOUNCE_CYCLES samples
    always_comb begin
        hit   = '0;
        db_d  = db_q;
        req_d = '0;
        cnt_d = '0;
        for (int i = 0; i < 2; i++) begin
            hit[i]   = (sync_q[i] != db_q[i]) && (cnt_q[i] + 8'd1 == DB_N);
            cnt_d[i] = (sync_q[i] == db_q[i] || hit[i]) ? 8'd0 : cnt_q[i] + 8'd1;
            db_d[i]  = hit[i] ? ~db_q[i] : db_q[i];
            req_d[i] = hit[i] & ~db_q[i];
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
            db_q   <= '0;
            req_q  <= '0;
            cnt_q  <= '0;
        end else begin
            meta_q <= {ctl_if.btn_dn, ctl_if.btn_up};
            sync_q <= meta_q;
            db_q   <= db_d;
            req_q  <= req_d;
            cnt_q  <= cnt_d;
        end
    end
    // pulses live only in PULSE; level moves on the same edge the pulse rises
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            inc_q   <= 1'b0;
            dec_q   <= 1'b0;
            level_q <= RST_L;
            busy_q  <= 1'b0;
            timer_q <= '0;
        end else begin
            busy_q <= ctl_if.ramp_mode && (level_q != tgt_c);
            inc_q  <= 1'b0;
            dec_q  <= 1'b0;
            if (!ctl_if.ramp_mode) timer_q <= '0;
            case (state_q)
                IDLE: begin
                    if (ctl_if.ramp_mode) begin
                        state_q <= RAMP_WAIT;
                        timer_q <= '0;
                    end else if (req_q == 2'b01 && level_q != MAX_L) begin
                        inc_q   <= 1'b1;
                        level_q <= level_q + 4'd1;
                        state_q <= PULSE;
                    end else if (req_q == 2'b10 && level_q != 4'd0) begin
                        dec_q   <= 1'b1;
                        level_q <= level_q - 4'd1;
                        state_q <= PULSE;
                    end
                end
                PULSE: state_q <= HOLD;
                HOLD:  state_q <= ctl_if.ramp_mode ? RAMP_WAIT : IDLE;
                RAMP_WAIT: begin
                    if (!ctl_if.ramp_mode) begin
                        state_q <= IDLE;
                    end else if (timer_q == RAMP_TC) begin
                        timer_q <= '0;
                        if (level_q < tgt_c) begin
                            inc_q   <= 1'b1;
                            level_q <= level_q + 4'd1;
                            state_q <= PULSE;
                        end else if (level_q > tgt_c) begin
                            dec_q   <= 1'b1;
                            level_q <= level_q - 4'd1;
                            state_q <= PULSE;
                        end
                    end else begin
                        timer_q <= timer_q + 16'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign ctl_if.duty_inc   = inc_q;
    assign ctl_if.duty_dec   = dec_q;
    assign ctl_if.duty_level = level_q;
    assign ctl_if.busy       = busy_q;
endmodule

// File: tb/tb_pwm_duty_ctrl.sv
// tb_pwm_duty_ctrl: randomized button/ramp stimulus against a step-level model of the duty controller
module tb_pwm_duty_ctrl;
    localparam int DB = 16, RI = 8, MAXL = 10, RSTL = 5;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic prev_any = 1'b0;
    int cyc = 0, n_chk = 0, n_err = 0, lvl_m = RSTL;
    int pulse_t[$];
    int pulse_k[$];
    pwm_duty_ctrl_if bus ();
    pwm_duty_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .RAMP_INTERVAL(RI),
        .MAX_LEVEL(MAXL),
        .RESET_LEVEL(RSTL)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .ctl_if(bus)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    // pulse log: cycle stamp and kind (0 inc, 1 dec); pulses are one cycle wide and never overlap
    always @(negedge clk) begin
        if (rst_n) begin
            chk("excl", int'(bus.duty_inc & bus.duty_dec), 0);
            chk("gap", int'((bus.duty_inc | bus.duty_dec) & prev_any), 0);
            if (bus.duty_inc | bus.duty_dec) begin
                pulse_t.push_back(cyc);
                pulse_k.push_back(bus.duty_dec ? 1 : 0);
            end
            prev_any <= bus.duty_inc | bus.duty_dec;
        end else begin
            prev_any <= 1'b0;
        end
    end
    function automatic int clampt(input int t);
        return (t > MAXL) ? MAXL : t;
    endfunction
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic clear_log();
        pulse_t.delete();
        pulse_k.delete();
    endtask
    task automatic ramp_off();
        bus.ramp_mode = 1'b0;
        step(3);
        chk("busy_idle", bus.busy, 0);
    endtask
    task automatic apply_reset();
        @(negedge clk);
        bus.ramp_mode = 1'b0;
        bus.btn_up = 1'b0;
        bus.btn_dn = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_inc", bus.duty_inc, 0);
        chk("rst_dec", bus.duty_dec, 0);
        chk("rst_lvl", bus.duty_level, RSTL);
        chk("rst_busy", bus.busy, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        lvl_m = RSTL;
        step(2);
    endtask
    // kind: 0 up, 1 down, 2 both on the same cycle
    task automatic press(input int kind, input bit bounce);
        int t0, lat, legal;
        if (bus.ramp_mode) ramp_off();
        step(1);
        clear_log();
        if (bounce)
            for (int i = 0; i < 10; i++) begin
                bus.btn_up = (kind != 1) && (i % 2 == 0);
                bus.btn_dn = (kind != 0) && (i % 2 == 0);
                step(3);
            end
        bus.btn_up = kind != 1;
        bus.btn_dn = kind != 0;
        t0 = cyc;
        step($urandom_range(25, 45));
        bus.btn_up = 1'b0;
        bus.btn_dn = 1'b0;
        step($urandom_range(22, 40));
        legal = int'((kind == 0 && lvl_m < MAXL) || (kind == 1 && lvl_m > 0));
        chk($sformatf("npulse k%0d l%0d", kind, lvl_m), pulse_t.size(), legal);
        if (legal == 1 && pulse_t.size() == 1) begin
            lat = pulse_t[0] - t0;
            chk($sformatf("lat=%0d", lat), int'(lat >= (bounce ? 16 : 18) && lat <= 20), 1);
            chk("kind", pulse_k[0], kind);
        end
        if (legal == 1) lvl_m += (kind == 0) ? 1 : -1;
        chk("level", bus.duty_level, lvl_m);
        chk("busy_man", bus.busy, 0);
    endtask
    task automatic ramp(input int tgt, input bit poke);
        int tc, steps, dir, sp;
        bit fresh;
        tc    = clampt(tgt);
        steps = (lvl_m > tc) ? lvl_m - tc : tc - lvl_m;
        dir   = (lvl_m < tc) ? 0 : 1;
        fresh = !bus.ramp_mode;
        clear_log();
        bus.target = 4'(tgt);
        bus.ramp_mode = 1'b1;
        step(3);
        if (fresh || steps != 1) chk("busy_on", bus.busy, int'(steps != 0));
        step(steps * 10 + 25);
        chk($sformatf("nramp t%0d", tgt), pulse_t.size(), steps);
        for (int i = 0; i < pulse_t.size(); i++) begin
            chk("rdir", pulse_k[i], dir);
            if (i > 0) begin
                sp = pulse_t[i] - pulse_t[i-1];
                chk($sformatf("rspace=%0d", sp), int'(sp >= 8 && sp <= 10), 1);
            end
        end
        lvl_m = tc;
        chk("rlevel", bus.duty_level, tc);
        chk("busy_done", bus.busy, 0);
        if (poke) begin
            clear_log();
            if ($urandom_range(0, 1) == 1) bus.btn_up = 1'b1;
            else bus.btn_dn = 1'b1;
            step(30);
            bus.btn_up = 1'b0;
            bus.btn_dn = 1'b0;
            step(25);
            chk("rbtn", pulse_t.size(), 0);
            chk("rbtn_lvl", bus.duty_level, lvl_m);
        end
    endtask
    task automatic rst_mid();
        int w = 0;
        if (bus.ramp_mode) ramp_off();
        if (lvl_m == MAXL) press(1, 1'b0);
        step(1);
        bus.btn_up = 1'b1;
        while (!bus.duty_inc && w < 40) begin
            @(negedge clk);
            w++;
        end
        chk("rst_seen", int'(bus.duty_inc), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_inc", bus.duty_inc, 0);
        chk("mid_lvl", bus.duty_level, RSTL);
        chk("mid_busy", bus.busy, 0);
        bus.btn_up = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        lvl_m = RSTL;
        clear_log();
        step(30);
        chk("post_rst", pulse_t.size(), 0);
        chk("post_lvl", bus.duty_level, RSTL);
    endtask
    initial begin
        int sel;
        bus.btn_up = 1'b0;
        bus.btn_dn = 1'b0;
        bus.ramp_mode = 1'b0;
        bus.target = 4'd0;
        apply_reset();
        press(0, 1'b0);
        press(0, 1'b1);
        press(2, 1'b0);
        rst_mid();
        repeat (6) press(0, 1'b0);
        apply_reset();
        ramp(2, 1'b0);
        ramp(15, 1'b0);
        ramp(0, 1'b1);
        ramp_off();
        press(1, 1'b0);
        for (int n = 0; n < 40; n++) begin
            sel = $urandom_range(0, 11);
            if (sel < 7) press($urandom_range(0, 2), 1'($urandom_range(0, 1)));
            else if (sel < 10) begin
                ramp($urandom_range(0, 15), 1'($urandom_range(0, 1)));
                if ($urandom_range(0, 1) == 1) ramp_off();
            end else if (sel == 10) rst_mid();
            else apply_reset();
        end
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
